// File: rtl/ffa_master.sv
// ffa_master: single-outstanding request master for a flat array port.
// Reads that report an array error are re-issued up to RETRY_N times.
module ffa_master #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int RETRY_N = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_wr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              ffa_wr,
   output logic              ffa_rd,
   output logic [ADDR_W-1:0] ffa_addr,
   output logic [DATA_W-1:0] ffa_din,
   input  logic [DATA_W-1:0] ffa_dout,
   input  logic              ffa_error,
   output logic [15:0]       err_cnt
);

   localparam int RW = (RETRY_N < 1) ? 1 : $clog2(RETRY_N + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP,
      RESP
   } state_t;

   state_t              state_q;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [RW-1:0]       retry_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic                rsp_wr_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_err_q;
   logic                ffa_wr_q;
   logic                ffa_rd_q;
   logic [15:0]         err_cnt_q;

   logic                retry_d;
   logic [15:0]         err_cnt_d;
   logic [DATA_W-1:0]   rsp_data_d;

   // Retry decision, saturating error count and response data for ISSUE exit
   always_comb begin
      retry_d    = 1'b0;
      err_cnt_d  = err_cnt_q;
      rsp_data_d = '0;
      if (!wr_q && ffa_error && (int'(retry_q) < RETRY_N)) begin
         retry_d = 1'b1;
      end
      if (ffa_error && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
      if (!wr_q) begin
         rsp_data_d = ffa_dout;
      end
   end

   // Request/response FSM with all outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         retry_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         ffa_wr_q    <= 1'b0;
         ffa_rd_q    <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  wr_q        <= req_wr;
                  addr_q      <= req_addr;
                  data_q      <= req_data;
                  retry_q     <= '0;
                  req_ready_q <= 1'b0;
                  ffa_wr_q    <= req_wr;
                  ffa_rd_q    <= ~req_wr;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               ffa_wr_q <= 1'b0;
               ffa_rd_q <= 1'b0;
               if (retry_d) begin
                  retry_q <= retry_q + RW'(1);
                  state_q <= GAP;
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= wr_q;
                  rsp_data_q  <= rsp_data_d;
                  rsp_err_q   <= ffa_error;
                  err_cnt_q   <= err_cnt_d;
                  state_q     <= RESP;
               end
            end
            GAP: begin
               // only reads are ever retried
               ffa_rd_q <= 1'b1;
               state_q  <= ISSUE;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  retry_q     <= '0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               ffa_wr_q    <= 1'b0;
               ffa_rd_q    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_wr    = rsp_wr_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign ffa_wr    = ffa_wr_q;
   assign ffa_rd    = ffa_rd_q;
   assign ffa_addr  = addr_q;
   assign ffa_din   = data_q;
   assign err_cnt   = err_cnt_q;

endmodule
